// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the converter state enum and BCD geometry.
package seg_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } conv_state_t;

  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 8;
  localparam int BCD_TOT_W  = BCD_W * BCD_DIGITS;
  localparam int SREG_W     = BCD_TOT_W + BIN_W;
  localparam int CNT_W      = $clog2(BIN_W);

  localparam logic [BCD_W-1:0] ADD3_THR = 4'd5;
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(BIN_W - 1);

endpackage

// File: rtl/BCD2Sseg.sv
// BCD digit to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
// Ports: bcd (4-bit digit) -> sseg (7 segments, 0 = lit).
module BCD2Sseg (
  input  logic [3:0] bcd,
  output logic [6:0] sseg
);

  always_comb begin
    sseg = 7'b1111111;
    unique case (bcd)
      4'd0:    sseg = 7'b1000000;
      4'd1:    sseg = 7'b1111001;
      4'd2:    sseg = 7'b0100100;
      4'd3:    sseg = 7'b0110000;
      4'd4:    sseg = 7'b0011001;
      4'd5:    sseg = 7'b0010010;
      4'd6:    sseg = 7'b0000010;
      4'd7:    sseg = 7'b1111000;
      4'd8:    sseg = 7'b0000000;
      4'd9:    sseg = 7'b0010000;
      default: sseg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl_bin2bcd.sv
// Iterative double-dabble binary to BCD converter (8 cycles).
// Ports: load_i/num_i in, busy_o, done_o (last iteration), bcd_o.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [BIN_W-1:0]     num_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [BCD_TOT_W-1:0] bcd_o
);

  conv_state_t       state_q;
  logic [SREG_W-1:0] sreg_q;
  logic [SREG_W-1:0] adj;
  logic [SREG_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  always_comb begin
    adj = sreg_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[BIN_W+BCD_W*d +: BCD_W] >= ADD3_THR)
        adj[BIN_W+BCD_W*d +: BCD_W] =
          adj[BIN_W+BCD_W*d +: BCD_W] + 4'd3;
    end
    shifted = {adj[SREG_W-2:0], 1'b0};
  end

  // bcd_o is the result of the iteration in flight; the
  // caller captures it on the edge where done_o is high.
  assign bcd_o  = shifted[SREG_W-1:BIN_W];
  assign done_o = (state_q == SHIFT) && (cnt_q == LAST_IT);
  assign busy_o = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_i) begin
            sreg_q  <= {{BCD_TOT_W{1'b0}}, num_i};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sreg_q <= shifted;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_IT) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment controller: BCD conversion plus digit scanning.
// Ports: num_i/load_i in; busy_o, sseg_o, an_o (active-low) out.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DISPLAYS = 3,
  parameter int SEGMENTS = 7,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          num_i,
  input  logic                load_i,
  output logic                busy_o,
  output logic [SEGMENTS-1:0] sseg_o,
  output logic [DISPLAYS-1:0] an_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DISPLAYS);

  localparam logic [PW-1:0] PRE_TC  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(DISPLAYS - 1);

  logic                 conv_done;
  logic [BCD_TOT_W-1:0] conv_bcd;

  logic [BCD_TOT_W-1:0] disp_q;
  logic [BCD_TOT_W-1:0] disp_nxt;
  logic [PW-1:0]        presc_q;
  logic [PW-1:0]        presc_nxt;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_nxt;
  logic [DISPLAYS-1:0]  an_q;
  logic [DISPLAYS-1:0]  an_nxt;
  logic [15:0]          dig16;
  logic [3:0]           cur_nib;
  logic                 tc;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_i),
    .num_i  (num_i),
    .busy_o (busy_o),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  // Digit k>0 is dark when it and every displayed digit
  // above it are zero. Digit 3 (if present) is always zero.
  function automatic logic is_blank(
    input logic [15:0] d,
    input int          k
  );
    logic z;
    z = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j >= k && j < DISPLAYS && j < BCD_DIGITS &&
          d[4*j +: 4] != 4'd0)
        z = 1'b0;
    end
    return (BLANK_LZ != 0) && (k > 0) && z;
  endfunction

  always_comb begin
    tc        = (presc_q == PRE_TC);
    presc_nxt = tc ? '0 : presc_q + 1'b1;
    idx_nxt   = idx_q;
    if (tc)
      idx_nxt = (idx_q == IDX_TOP) ? '0 : idx_q + 1'b1;
    disp_nxt  = conv_done ? conv_bcd : disp_q;
    // an_o is registered from next-state index and data so
    // it always agrees with sseg_o in the following cycle.
    if (is_blank({4'b0, disp_nxt}, int'(idx_nxt)))
      an_nxt = '1;
    else
      an_nxt = ~(DISPLAYS'(1) << idx_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      an_q    <= ~DISPLAYS'(1);
    end else begin
      presc_q <= presc_nxt;
      idx_q   <= idx_nxt;
      disp_q  <= disp_nxt;
      an_q    <= an_nxt;
    end
  end

  always_comb begin
    dig16   = {4'b0, disp_q};
    cur_nib = dig16[4*int'(idx_q) +: 4];
  end

  BCD2Sseg u_seg (
    .bcd  (cur_nib),
    .sseg (sseg_o)
  );

  assign an_o = an_q;

endmodule
